// File: rtl/vga_sync_gen_pkg.sv
// Default 640x480@60 raster geometry, derived sync windows and pin field widths
// shared by the VGA timing generator and its interface.
package vga_timing_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  localparam int CNT_W = 10;
  localparam int R_W   = 3;
  localparam int G_W   = 3;
  localparam int B_W   = 2;
  localparam int RGB_W = R_W + G_W + B_W;

  // Signals that must travel alongside the renderer pipeline.
  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, active: 1'b0};

  function automatic logic in_range(input logic [CNT_W-1:0] v,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction
endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster/renderer handshake plus VGA DAC pins; master is the timing generator,
// slave is the renderer / pin consumer.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic             px_en;
  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic             active;
  logic             line_start;
  logic             frame_start;
  logic [RGB_W-1:0] pixel_rgb_in;
  logic [R_W-1:0]   vga_r;
  logic [G_W-1:0]   vga_g;
  logic [B_W-1:0]   vga_b;
  logic             vga_hs;
  logic             vga_vs;

  modport master (
    output px_en, hcount, vcount, active, line_start, frame_start,
    output vga_r, vga_g, vga_b, vga_hs, vga_vs,
    input  pixel_rgb_in
  );

  modport slave (
    input  px_en, hcount, vcount, active, line_start, frame_start,
    input  vga_r, vga_g, vga_b, vga_hs, vga_vs,
    output pixel_rgb_in
  );
endinterface

// File: rtl/vga_sync_gen_px_delay_line.sv
// Pixel-enable gated shift register; DEPTH=0 collapses to a wire.
module px_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_ctl;
      assign unused_ctl = ^{clk, reset, en, rst_val};
      assign q = d;
    end else begin : g_pipe
      logic [DEPTH-1:0][WIDTH-1:0] pipe;
      always_ff @(posedge clk) begin
        if (reset) begin
          pipe <= {DEPTH{rst_val}};
        end else if (en) begin
          pipe[0] <= d;
          for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign q = pipe[DEPTH-1];
    end
  endgenerate
endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel divider, h/v counters, sync decode re-aligned to the
// renderer latency, and the blanked RGB/sync output register.
module vga_sync_gen
  import vga_timing_pkg::CNT_W, vga_timing_pkg::RGB_W, vga_timing_pkg::sync_t,
         vga_timing_pkg::SYNC_IDLE, vga_timing_pkg::in_range;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP,
  parameter int PIPE_DLY = 2
) (
  input logic            clk,
  input logic            reset,
  vga_sync_gen_if.master bus
);
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             px_en;
  logic [CNT_W-1:0] hcount, vcount, h_nxt, v_nxt;
  logic             active;
  sync_t            raw, dly;
  logic [RGB_W-1:0] rgb_q;
  logic             hs_q, vs_q;

  always_ff @(posedge clk) begin
    if (reset)                 div_cnt <= '0;
    else if (div_cnt == DIV_LAST) div_cnt <= '0;
    else                       div_cnt <= div_cnt + 1'b1;
  end

  // Gated by reset so a divide-by-1 build still idles while held in reset.
  assign px_en = (div_cnt == DIV_LAST) && !reset;

  always_comb begin
    h_nxt = hcount + 1'b1;
    v_nxt = vcount;
    if (hcount == H_LAST) begin
      h_nxt = '0;
      v_nxt = (vcount == V_LAST) ? '0 : vcount + 1'b1;
    end
  end

  // active is registered from the next position so it lines up with hcount/vcount.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
      active <= 1'b1;
    end else if (px_en) begin
      hcount <= h_nxt;
      vcount <= v_nxt;
      active <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
    end
  end

  always_comb begin
    raw.hs     = !in_range(hcount, HS_START, HS_END);
    raw.vs     = !in_range(vcount, VS_START, VS_END);
    raw.active = active;
  end

  px_delay_line #(.WIDTH($bits(sync_t)), .DEPTH(PIPE_DLY)) u_dly (
    .clk     (clk),
    .reset   (reset),
    .en      (px_en),
    .rst_val (SYNC_IDLE),
    .d       (raw),
    .q       (dly)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else if (px_en) begin
      rgb_q <= dly.active ? bus.pixel_rgb_in : '0;
      hs_q  <= dly.hs;
      vs_q  <= dly.vs;
    end
  end

  assign bus.px_en       = px_en;
  assign bus.hcount      = hcount;
  assign bus.vcount      = vcount;
  assign bus.active      = active;
  assign bus.line_start  = px_en && (hcount == '0);
  assign bus.frame_start = px_en && (hcount == '0) && (vcount == '0);
  assign {bus.vga_r, bus.vga_g, bus.vga_b} = rgb_q;
  assign bus.vga_hs      = hs_q;
  assign bus.vga_vs      = vs_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen on a shrunken 16x8 raster (30x15 totals) so whole frames fit
// in a short run; a position-formula scoreboard checks every pixel tick.
module tb_vga_sync_gen;
  localparam int HA = 16, HF = 4, HS = 6, HB = 4;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;  // 30
  localparam int VT = VA + VF + VS + VB;  // 15
  localparam int PD = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mode = 1'b0;  // 0: renderer outputs FF, 1: renderer outputs hcount[7:0]
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  vga_sync_gen_if bus ();

  vga_sync_gen #(
    .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .PIPE_DLY(PD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Renderer stand-in: PD-tick registered pipeline of the raster column.
  logic [7:0] rpipe0, rpipe1;
  always @(posedge clk) begin
    if (reset) begin
      rpipe0 <= 8'h00;
      rpipe1 <= 8'h00;
    end else if (bus.px_en) begin
      rpipe0 <= bus.hcount[7:0];
      rpipe1 <= rpipe0;
    end
  end
  assign bus.pixel_rgb_in = mode ? rpipe1 : 8'hFF;

  // Expected bundle {hcount, vcount, active, line_start, frame_start, hs, vs, rgb}
  // after mm px_en ticks since reset; pins reflect position mm-1-PD.
  function automatic logic [32:0] model(input int mm);
    int h, v, p, ph, pv;
    logic act, ls, fs, ehs, evs;
    logic [7:0] rgb;
    h = mm % HT;
    v = (mm / HT) % VT;
    act = (h < HA) && (v < VA);
    ls  = (h == 0);
    fs  = (h == 0) && (v == 0);
    p = mm - 1 - PD;
    if (p < 0) begin
      ehs = 1'b1; evs = 1'b1; rgb = 8'h00;
    end else begin
      ph  = p % HT;
      pv  = (p / HT) % VT;
      ehs = !((ph >= HA + HF) && (ph < HA + HF + HS));
      evs = !((pv >= VA + VF) && (pv < VA + VF + VS));
      rgb = ((ph < HA) && (pv < VA)) ? (mode ? 8'(ph) : 8'hFF) : 8'h00;
    end
    return {10'(h), 10'(v), act, ls, fs, ehs, evs, rgb};
  endfunction

  logic [32:0] sbq[$];
  int          m = 0;
  bit          primed = 1'b0;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      sbq.delete();
      m = 0;
      primed = 1'b0;
    end else begin
      if (!primed) begin
        sbq.push_back(model(0));
        primed = 1'b1;
      end
      if (bus.px_en) begin
        m++;
        sbq.push_back(model(m));
      end
    end
  end

  initial forever begin
    logic [32:0] want, got;
    @(negedge clk);
    if (!reset && bus.px_en) begin
      got = {bus.hcount, bus.vcount, bus.active, bus.line_start, bus.frame_start,
             bus.vga_hs, bus.vga_vs, bus.vga_r, bus.vga_g, bus.vga_b};
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL sb_empty: got %h with no expected entry", got);
      end else begin
        want = sbq.pop_front();
        if (got !== want) begin
          fails++;
          $display("FAIL sb_tick h=%0d v=%0d: got %h expected %h (h,v,act,ls,fs,hs,vs,rgb)",
                   want[32:23], want[22:13], got, want);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // sel 0: px_en, 1: line_start, 2: frame_start; sampled at posedge before update.
  task automatic wait_evt(input int sel, output int clks);
    logic hit;
    clks = 0;
    do begin
      @(posedge clk);
      clks++;
      hit = (sel == 0) ? bus.px_en : (sel == 1) ? bus.line_start : bus.frame_start;
    end while (!hit && clks < 2000);
    if (!hit) begin
      tests++; fails++;
      $display("FAIL wait_evt%0d: timeout after %0d clks", sel, clks);
    end
  endtask

  task automatic wait_pos(input int h, input int v);
    int c;
    logic hit;
    c = 0;
    do begin
      @(negedge clk);
      c++;
      hit = bus.px_en && (bus.hcount == 10'(h)) && (bus.vcount == 10'(v));
    end while (!hit && c < 3000);
    if (!hit) begin
      tests++; fails++;
      $display("FAIL wait_pos(%0d,%0d): timeout", h, v);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t, first, low, lines, clks;

    // Reset state
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_px_en", bus.px_en, 0);
    check("rst_hcount", bus.hcount, 0);
    check("rst_vcount", bus.vcount, 0);
    check("rst_line_start", bus.line_start, 0);
    check("rst_frame_start", bus.frame_start, 0);
    check("rst_hs", bus.vga_hs, 1);
    check("rst_vs", bus.vga_vs, 1);
    check("rst_rgb", {bus.vga_r, bus.vga_g, bus.vga_b}, 8'h00);

    // Reset release and divider cadence
    @(posedge clk); #1 reset = 1'b0;
    wait_evt(0, n); check("first_px_en_clks", n, 2);
    wait_evt(0, n); check("px_en_period1", n, 2);
    wait_evt(0, n); check("px_en_period2", n, 2);

    // Line timing: hs low ticks 23..28 (20+PD+1 for 6 ticks)
    wait_evt(1, n);
    wait_evt(1, n);
    t = 0; first = -1; low = 0;
    do begin
      if (!bus.vga_hs) begin
        if (first < 0) first = t;
        low++;
      end
      wait_evt(0, n);
      t++;
    end while (!bus.line_start && t < 100);
    check("line_ticks", t, 30);
    check("hs_first_tick", first, 23);
    check("hs_width", low, 6);

    // Frame timing: vs low from tick 10*30+3 for 2 lines
    wait_evt(2, n);
    t = 0; first = -1; low = 0; lines = 0; clks = 0;
    do begin
      if (bus.line_start) lines++;
      if (!bus.vga_vs) begin
        if (first < 0) first = t;
        low++;
      end
      wait_evt(0, n);
      clks += n;
      t++;
    end while (!bus.frame_start && t < 1000);
    check("frame_ticks", t, 450);
    check("frame_clks", clks, 900);
    check("frame_lines", lines, 15);
    check("vs_first_tick", first, 303);
    check("vs_width", low, 60);

    // Blanking corners with constant FF
    wait_pos(3, 0);  check("blank_px_0_0", {bus.vga_r, bus.vga_g, bus.vga_b}, 8'hFF);
    wait_pos(18, 7); check("blank_px_15_7", {bus.vga_r, bus.vga_g, bus.vga_b}, 8'hFF);
    wait_pos(19, 7); check("blank_px_16_7", {bus.vga_r, bus.vga_g, bus.vga_b}, 8'h00);
    wait_pos(3, 8);  check("blank_px_0_8", {bus.vga_r, bus.vga_g, bus.vga_b}, 8'h00);

    // Alignment with renderer emitting its column
    @(posedge clk); #1 reset = 1'b1; mode = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    wait_pos(8, 2);  check("align_k5", {bus.vga_r, bus.vga_g, bus.vga_b}, 8'h05);
    wait_pos(18, 3); check("align_k15", {bus.vga_r, bus.vga_g, bus.vga_b}, 8'h0F);
    wait_pos(19, 3); check("align_k16_blank", {bus.vga_r, bus.vga_g, bus.vga_b}, 8'h00);

    // Mid-frame reset while vsync is low
    wait_pos(13, 10);
    check("pre_rst_vs_low", bus.vga_vs, 0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_hcount", bus.hcount, 0);
    check("mid_rst_vcount", bus.vcount, 0);
    check("mid_rst_hs", bus.vga_hs, 1);
    check("mid_rst_vs", bus.vga_vs, 1);
    check("mid_rst_rgb", {bus.vga_r, bus.vga_g, bus.vga_b}, 8'h00);
    @(posedge clk); #1 reset = 1'b0;
    wait_evt(2, n); check("restart_first_fs_clks", n, 2);
    wait_evt(2, n); check("restart_next_fs_clks", n, 900);

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
